// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one single-port data RAM between the CPU (m0) and a DMA/debug loader (m1)
module dm_port_arbiter #(
  parameter int DEPTH_WORDS = 4096,
  parameter int READ_LAT = 1,
  parameter int PRIO_M0 = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        we_0,
  input  logic        we_1,
  input  logic [31:0] addr_0,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_0,
  input  logic [31:0] wdata_1,
  input  logic [3:0]  be_0,
  input  logic [3:0]  be_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        rvalid_0,
  output logic        rvalid_1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  state_t state;
  logic last, win, l_we, l_inr;
  logic [3:0] cnt;
  logic pick_1, sel_inr;
  logic [31:0] sel_addr;
  // winner selection: a lone requester always wins, a tie goes to priority or to the master not served last
  always_comb begin
    pick_1 = req_1 && (!req_0 || (PRIO_M0 == 0 && !last));
    sel_addr = pick_1 ? addr_1 : addr_0;
    sel_inr = {1'b0, sel_addr} < LIMIT;
  end
  // transaction sequencer; every output is a register loaded on the transition into the state that shows it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      win <= 1'b0;
      l_we <= 1'b0;
      l_inr <= 1'b0;
      cnt <= '0;
      gnt_0 <= 1'b0;
      gnt_1 <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else begin
      case (state)
        IDLE: if (req_0 || req_1) begin
          state <= ACCESS;
          busy <= 1'b1;
          last <= pick_1;
          win <= pick_1;
          l_we <= pick_1 ? we_1 : we_0;
          l_inr <= sel_inr;
          gnt_0 <= !pick_1;
          gnt_1 <= pick_1;
          mem_en <= sel_inr;
          mem_we <= sel_inr && (pick_1 ? we_1 : we_0);
          mem_addr <= sel_addr[31:2];
          mem_wdata <= pick_1 ? wdata_1 : wdata_0;
          mem_be <= pick_1 ? be_1 : be_0;
        end
        ACCESS: begin
          gnt_0 <= 1'b0;
          gnt_1 <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt <= 4'(READ_LAT);
          state <= l_inr ? WAIT : RESP;
          if (!l_inr) begin
            rvalid_0 <= !win;
            rvalid_1 <= win;
            err <= 1'b1;
            rdata <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            rvalid_0 <= !win;
            rvalid_1 <= win;
            rdata <= l_we ? '0 : mem_rdata;
          end
        end
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
          rvalid_0 <= 1'b0;
          rvalid_1 <= 1'b0;
          rdata <= '0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: timeline model plus directed vectors for a round-robin READ_LAT=1 and a fixed-priority READ_LAT=3 arbiter
module tb_dm_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic req_0 [2], req_1 [2], we_0 [2], we_1 [2];
  logic [31:0] addr_0 [2], addr_1 [2], wdata_0 [2], wdata_1 [2];
  logic [3:0] be_0 [2], be_1 [2];
  logic gnt_0 [2], gnt_1 [2], rvalid_0 [2], rvalid_1 [2], err [2], busy [2], mem_en [2], mem_we [2];
  logic [31:0] rdata [2], mem_wdata [2], mem_rdata [2];
  logic [29:0] mem_addr [2];
  logic [3:0] mem_be [2];
  logic [31:0] em [2][4096];
  logic [31:0] mm [2][4096];
  logic [31:0] pipe [2][16];
  int tests = 0, fails = 0, cyc = 0;
  int dq0[$], dq1[$];
  int s [2], r [2];
  bit mw1 [2], mwe [2], minr [2], mlast [2];
  logic [31:0] maddr [2], mwd [2], mexp [2];
  logic [3:0] mbe [2];

  always #5 clk = ~clk;

  dm_port_arbiter #(.DEPTH_WORDS(4096), .READ_LAT(1), .PRIO_M0(0)) dut_a (
    .clk(clk), .reset(rst_n), .req_0(req_0[0]), .req_1(req_1[0]), .we_0(we_0[0]), .we_1(we_1[0]),
    .addr_0(addr_0[0]), .addr_1(addr_1[0]), .wdata_0(wdata_0[0]), .wdata_1(wdata_1[0]),
    .be_0(be_0[0]), .be_1(be_1[0]), .gnt_0(gnt_0[0]), .gnt_1(gnt_1[0]),
    .rvalid_0(rvalid_0[0]), .rvalid_1(rvalid_1[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0]));

  dm_port_arbiter #(.DEPTH_WORDS(4096), .READ_LAT(3), .PRIO_M0(1)) dut_b (
    .clk(clk), .reset(rst_n), .req_0(req_0[1]), .req_1(req_1[1]), .we_0(we_0[1]), .we_1(we_1[1]),
    .addr_0(addr_0[1]), .addr_1(addr_1[1]), .wdata_0(wdata_0[1]), .wdata_1(wdata_1[1]),
    .be_0(be_0[1]), .be_1(be_1[1]), .gnt_0(gnt_0[1]), .gnt_1(gnt_1[1]),
    .rvalid_0(rvalid_0[1]), .rvalid_1(rvalid_1[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1]));

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM environment: byte-lane writes, read data appears READ_LAT cycles after the strobe and is junk otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] && mem_we[k])
        for (int b = 0; b < 4; b++)
          if (mem_be[k][b]) em[k][mem_addr[k][11:0]][8*b +: 8] = mem_wdata[k][8*b +: 8];
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? em[k][mem_addr[k][11:0]] : 32'hBAD0_BAD0;
      for (int j = 1; j < 16; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end

  // grant order actually produced by each arbiter
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt_0[0]) dq0.push_back(0);
      if (gnt_1[0]) dq0.push_back(1);
      if (gnt_0[1]) dq1.push_back(0);
      if (gnt_1[1]) dq1.push_back(1);
    end
  end

  // model: each accepted request is a timeline (grant cycle s, response cycle r); outputs are compared every cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int lat;
      bit w1, strobe;
      logic [31:0] a;
      lat = (k == 0) ? 1 : 3;
      if (!rst_n) begin
        check($sformatf("rst_gnt_0[%0d]", k), 32'(gnt_0[k]), 0);
        check($sformatf("rst_gnt_1[%0d]", k), 32'(gnt_1[k]), 0);
        check($sformatf("rst_rvalid_0[%0d]", k), 32'(rvalid_0[k]), 0);
        check($sformatf("rst_rvalid_1[%0d]", k), 32'(rvalid_1[k]), 0);
        check($sformatf("rst_rdata[%0d]", k), rdata[k], 0);
        check($sformatf("rst_err[%0d]", k), 32'(err[k]), 0);
        check($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
        check($sformatf("rst_mem_en[%0d]", k), 32'(mem_en[k]), 0);
        check($sformatf("rst_mem_we[%0d]", k), 32'(mem_we[k]), 0);
        check($sformatf("rst_mem_addr[%0d]", k), 32'(mem_addr[k]), 0);
        check($sformatf("rst_mem_wdata[%0d]", k), mem_wdata[k], 0);
        check($sformatf("rst_mem_be[%0d]", k), 32'(mem_be[k]), 0);
        s[k] = -10;
        r[k] = -10;
        mlast[k] = 1'b1;
      end else begin
        strobe = (cyc == s[k]) && minr[k];
        check($sformatf("gnt_0[%0d]", k), 32'(gnt_0[k]), 32'(cyc == s[k] && !mw1[k]));
        check($sformatf("gnt_1[%0d]", k), 32'(gnt_1[k]), 32'(cyc == s[k] && mw1[k]));
        check($sformatf("mem_en[%0d]", k), 32'(mem_en[k]), 32'(strobe));
        check($sformatf("mem_we[%0d]", k), 32'(mem_we[k]), 32'(strobe && mwe[k]));
        if (strobe) begin
          check($sformatf("mem_addr[%0d]", k), 32'(mem_addr[k]), {2'b00, maddr[k][31:2]});
          check($sformatf("mem_wdata[%0d]", k), mem_wdata[k], mwd[k]);
          check($sformatf("mem_be[%0d]", k), 32'(mem_be[k]), 32'(mbe[k]));
        end
        check($sformatf("rvalid_0[%0d]", k), 32'(rvalid_0[k]), 32'(cyc == r[k] && !mw1[k]));
        check($sformatf("rvalid_1[%0d]", k), 32'(rvalid_1[k]), 32'(cyc == r[k] && mw1[k]));
        if (cyc == r[k]) begin
          check($sformatf("rdata[%0d]", k), rdata[k], mexp[k]);
          check($sformatf("err[%0d]", k), 32'(err[k]), 32'(!minr[k]));
        end
        check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(cyc >= s[k] && cyc <= r[k]));
        if (cyc > r[k] && (req_0[k] || req_1[k])) begin
          w1 = !req_0[k] ? 1'b1 : (!req_1[k] ? 1'b0 : (k == 0 && !mlast[k]));
          a = w1 ? addr_1[k] : addr_0[k];
          mw1[k] = w1;
          mlast[k] = w1;
          maddr[k] = a;
          mwe[k] = w1 ? we_1[k] : we_0[k];
          mwd[k] = w1 ? wdata_1[k] : wdata_0[k];
          mbe[k] = w1 ? be_1[k] : be_0[k];
          minr[k] = a < 32'd16384;
          s[k] = cyc + 1;
          r[k] = minr[k] ? s[k] + lat + 1 : s[k] + 1;
          mexp[k] = 0;
          if (minr[k] && mwe[k]) begin
            for (int b = 0; b < 4; b++)
              if (mbe[k][b]) mm[k][a[13:2]][8*b +: 8] = mwd[k][8*b +: 8];
          end else if (minr[k]) mexp[k] = mm[k][a[13:2]];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req_0[k] = 0; req_1[k] = 0; we_0[k] = 0; we_1[k] = 0;
      addr_0[k] = 0; addr_1[k] = 0; wdata_0[k] = 0; wdata_1[k] = 0; be_0[k] = 0; be_1[k] = 0;
    end
  endtask

  task automatic txn(input int k, input int m, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic e);
    int n;
    bit g;
    rd = 'x;
    e = 1'bx;
    if (m == 0) begin req_0[k] = 1; we_0[k] = we; addr_0[k] = a; wdata_0[k] = wd; be_0[k] = be; end
    else begin req_1[k] = 1; we_1[k] = we; addr_1[k] = a; wdata_1[k] = wd; be_1[k] = be; end
    n = 0;
    g = 0;
    while (!g && n < 20) begin
      tick();
      g = (m == 0) ? gnt_0[k] : gnt_1[k];
      n++;
    end
    req_0[k] = 0;
    req_1[k] = 0;
    if (!g) begin
      tests++; fails++;
      $display("FAIL txn_gnt_timeout: got no grant expected grant within 20 cycles");
      return;
    end
    n = 0;
    g = 0;
    while (!g && n < 20) begin
      tick();
      g = (m == 0) ? rvalid_0[k] : rvalid_1[k];
      n++;
    end
    if (!g) begin
      tests++; fails++;
      $display("FAIL txn_rvalid_timeout: got no rvalid expected rvalid within 20 cycles");
      return;
    end
    rd = rdata[k];
    e = err[k];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic e;
    int ones;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4096; i++) begin
        em[k][i] = {16'hC0DE, 16'(i)};
        mm[k][i] = {16'hC0DE, 16'(i)};
      end
    em[0][4] = 32'hDEAD_BEEF;
    mm[0][4] = 32'hDEAD_BEEF;
    em[1][4] = 32'hDEAD_BEEF;
    mm[1][4] = 32'hDEAD_BEEF;
    clear_inputs();
    rst_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        req_0[k] = 1'($urandom); req_1[k] = 1'($urandom);
        we_0[k] = 1'($urandom); addr_0[k] = $urandom; addr_1[k] = $urandom;
      end
    end
    tick();
    clear_inputs();
    rst_n = 1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_mem_en", 32'(mem_en[0]), 0);
    check("idle_busy", 32'(busy[0]), 0);

    // m0 read of word 4, READ_LAT=1
    req_0[0] = 1; we_0[0] = 0; addr_0[0] = 32'h10;
    tick();
    check("rd_t1_gnt_0", 32'(gnt_0[0]), 1);
    check("rd_t1_mem_en", 32'(mem_en[0]), 1);
    check("rd_t1_mem_we", 32'(mem_we[0]), 0);
    check("rd_t1_mem_addr", 32'(mem_addr[0]), 4);
    req_0[0] = 0;
    tick();
    tick();
    check("rd_t3_rvalid_0", 32'(rvalid_0[0]), 1);
    check("rd_t3_rdata", rdata[0], 32'hDEAD_BEEF);
    check("rd_t3_err", 32'(err[0]), 0);
    tick();
    check("rd_t4_busy", 32'(busy[0]), 0);

    // m1 byte write into lane 1 of word 8, then read it back via m0
    txn(0, 1, 1, 32'h20, 32'h0000_AB00, 4'b0010, rd, e);
    check("wr_rdata", rd, 0);
    check("wr_err", 32'(e), 0);
    check("wr_ram_word8", em[0][8], 32'hC0DE_AB08);
    txn(0, 0, 0, 32'h20, 0, 0, rd, e);
    check("wr_readback", rd, 32'hC0DE_AB08);

    // last in-range word
    txn(0, 1, 0, 32'h3FFC, 0, 0, rd, e);
    check("edge_rdata", rd, 32'hC0DE_0FFF);
    check("edge_err", 32'(e), 0);

    // first out-of-range address: error response at T2, no strobe
    tick();
    req_0[0] = 1; we_0[0] = 0; addr_0[0] = 32'h4000;
    tick();
    check("oor_t1_gnt_0", 32'(gnt_0[0]), 1);
    check("oor_t1_mem_en", 32'(mem_en[0]), 0);
    req_0[0] = 0;
    tick();
    check("oor_t2_rvalid_0", 32'(rvalid_0[0]), 1);
    check("oor_t2_err", 32'(err[0]), 1);
    check("oor_t2_rdata", rdata[0], 0);
    tick();

    // ties held from reset release: round-robin on dut_a, fixed priority on dut_b
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      req_0[k] = 1; req_1[k] = 1; addr_0[k] = 32'h40; addr_1[k] = 32'h80;
    end
    dq0.delete();
    dq1.delete();
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < 26; i++) tick();
    clear_inputs();
    for (int i = 0; i < 8; i++) tick();
    check("rr_count_ge4", 32'(dq0.size() >= 4), 1);
    if (dq0.size() >= 4) begin
      check("rr_g0", 32'(dq0[0]), 0);
      check("rr_g1", 32'(dq0[1]), 1);
      check("rr_g2", 32'(dq0[2]), 0);
      check("rr_g3", 32'(dq0[3]), 1);
    end
    check("prio_count_ge3", 32'(dq1.size() >= 3), 1);
    ones = 0;
    foreach (dq1[i]) ones += dq1[i];
    check("prio_m1_grants", 32'(ones), 0);
    if (dq1.size() >= 3) check("prio_g0_2", 32'(dq1[0] + dq1[1] + dq1[2]), 0);

    // leave dut_a with last=m0, then reset dut_b in its second WAIT cycle
    txn(0, 0, 0, 32'h10, 0, 0, rd, e);
    check("pre_rst_rdata", rd, 32'hDEAD_BEEF);
    tick();
    req_0[1] = 1; we_0[1] = 0; addr_0[1] = 32'h10;
    tick();
    check("lat3_t1_gnt_0", 32'(gnt_0[1]), 1);
    req_0[1] = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    check("wait_rst_busy", 32'(busy[1]), 0);
    check("wait_rst_mem_en", 32'(mem_en[1]), 0);
    check("wait_rst_rvalid", 32'(rvalid_0[1]), 0);
    for (int k = 0; k < 2; k++) begin
      req_0[k] = 1; req_1[k] = 1; addr_0[k] = 32'h40; addr_1[k] = 32'h80;
    end
    dq0.delete();
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_tie_count", 32'(dq0.size() >= 1), 1);
    if (dq0.size() >= 1) check("post_rst_tie_first", 32'(dq0[0]), 0);
    clear_inputs();
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters:
  - m0: CPU MEM-stage load/store port.
  - m1: DMA/debug loader.
- Per transaction: arbitrates, range-checks the byte address, drives one memory strobe, waits out the read latency, returns a one-cycle response to the winner.
- Sits between the pipeline's memory stage and the data RAM; sub-word byte lane handling remains in the requester.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit memory words; valid byte addresses are 0 to DEPTH_WORDS*4-1.
- READ_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1-15.
- PRIO_M0, 0, 0 = round-robin; 1 = fixed priority for m0.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_0 / req_1  in  1  request from m0 / m1; held with its fields stable until gnt_x.
- we_0 / we_1  in  1  1 = write, 0 = read.
- addr_0 / addr_1  in  32  byte address.
- wdata_0 / wdata_1  in  32  write data.
- be_0 / be_1  in  4  byte enables for writes.
- gnt_0 / gnt_1  out  1  one-cycle pulse: request accepted.
- rvalid_0 / rvalid_1  out  1  one-cycle response pulse.
- rdata  out  32  read data, valid with rvalid_x; 0 for writes and errors.
- err  out  1  valid with rvalid_x: address out of range.
- busy  out  1  1 whenever state is not IDLE.
- mem_en  out  1  memory strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  30  word index, equal to addr[31:2].
- mem_wdata  out  32  write data to memory.
- mem_be  out  4  byte enables to memory.
- mem_rdata  in  32  memory read data.

Behaviour:
- All outputs are registered.
- Reset (reset=0, takes effect immediately, no clock needed):
  - state=IDLE.
  - All outputs 0.
  - Round-robin pointer last=1, so m0 wins the first tie.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request: remain in IDLE.
  - One requester: it wins, regardless of the pointer.
  - Both requesting, PRIO_M0=0: the master not equal to last wins.
  - Both requesting, PRIO_M0=1: m0 always wins.
  - On selection: latch the winner's we/addr/wdata/be and go to ACCESS.
  - last updates only on a grant.
- ACCESS (1 cycle):
  - gnt_winner=1.
  - In range (addr < DEPTH_WORDS*4): mem_en=1, mem_we=we, mem_addr, mem_wdata and mem_be from the latch; load counter=READ_LAT; next state WAIT.
  - Out of range: no mem_en; next state RESP with err=1.
- WAIT:
  - The counter decrements each cycle.
  - On the cycle it reaches the final count (READ_LAT cycles after ACCESS), capture mem_rdata for reads, or 0 for writes.
  - Then go to RESP.
- RESP (1 cycle):
  - rvalid_winner=1, with rdata and err.
  - Next state IDLE.
  - A request held in that cycle is sampled in IDLE on the following cycle.
- Timing with request seen in IDLE at T0:
  - gnt and mem strobe at T1.
  - Normal rvalid at T1+READ_LAT+1.
  - Error rvalid at T2.
- Writes also produce rvalid (ack) with err=0 and rdata=0.
- Outside ACCESS, mem_en=0 and mem_we=0.
- Requests arriving while busy are ignored until IDLE; the requester must keep req high.
- Deasserting req before gnt is illegal; behaviour is unspecified.
- Address boundary: DEPTH_WORDS*4-1 is in range; DEPTH_WORDS*4 and above are errors.
- Address misalignment is not checked here; the requester flags it.
- Reset mid-transaction:
  - The transaction is aborted; no rvalid is issued after release.
  - A write already strobed in ACCESS may have landed in memory.
  - last returns to 1.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 with random requests.
  - Required: all outputs 0, busy=0; after release, idle with no request gives no mem_en.
- m0 read, READ_LAT=1:
  - Stimulus: memory word 4 = 0xDEADBEEF; req_0 read at addr 0x10 at T0.
  - Required: gnt_0, mem_en=1, mem_we=0, mem_addr=4 at T1; rvalid_0=1, rdata=0xDEADBEEF, err=0 at T3; busy=0 at T4.
- Tie, round-robin (PRIO_M0=0):
  - Stimulus: req_0 and req_1 both held from reset release.
  - Required: grants in order m0, m1, m0, m1.
  - Stimulus: repeat with PRIO_M0=1.
  - Required: m0, m0, m0, and m1 starves while req_0 is held.
- m1 byte write:
  - Stimulus: addr 0x20, wdata 0x0000AB00, be 4'b0010.
  - Required: mem_en=1, mem_we=1, mem_addr=8, mem_be=4'b0010 for exactly one cycle; rvalid_1 with rdata=0, err=0.
- Range boundary (DEPTH_WORDS=4096):
  - Stimulus: addr 0x3FFC.
  - Required: normal access.
  - Stimulus: addr 0x4000.
  - Required: no mem_en; rvalid and err=1 at T2, rdata=0.
- Reset in WAIT (READ_LAT=3):
  - Stimulus: pull reset low during the second WAIT cycle.
  - Required: busy and mem_* are 0 immediately, with no rvalid; after release, a tie grants m0 first.
